// File: rtl/agusec_bnd_enc_pipe.sv
// Two-stage bounded-pointer encoder: packs {on_low, exp, hi, low, addr} into a 64-bit tagged pointer.
// Optional macro AGUSEC_BND_FAULT_EN adds out_fault and clears on_low for faulting entries.
module agusec_bnd_enc_pipe #(
    parameter int ADDR_W = 44,
    parameter int EXP_W  = 5,
    parameter int FLD_W  = 7,
    parameter int LSB_SH = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_vld,
    output logic                   in_rdy,
    input  logic [63:0]            in_ptr,
    input  logic [EXP_W+FLD_W-1:0] in_bnd,
    output logic                   out_vld,
    input  logic                   out_rdy,
    output logic [63:0]            out_ptr,
    output logic                   out_carry
`ifdef AGUSEC_BND_FAULT_EN
    ,
    output logic                   out_fault
`endif
);

    // Packed layout offsets; ADDR_W + 2*FLD_W + EXP_W + 1 must fit in 64 bits.
    localparam int LOW_LSB = ADDR_W;
    localparam int HI_LSB  = ADDR_W + FLD_W;
    localparam int EXP_LSB = ADDR_W + 2 * FLD_W;
    localparam int ONL_BIT = ADDR_W + 2 * FLD_W + EXP_W;

    // Handshake: a stage transfers on a clock edge when it holds valid data and the
    // downstream stage is empty or emptying; in_rdy never looks at in_vld.
    logic s1_vld;
    logic s2_vld;
    logic s2_adv;
    logic in_fire;
    logic s1_load_s2;

    logic [ADDR_W-1:0] in_addr;
    logic [EXP_W-1:0]  in_exp;
    logic [FLD_W-1:0]  in_len;
    logic [31:0]       in_sh_amt;
    logic [ADDR_W-1:0] in_shifted;
    logic [FLD_W-1:0]  in_low;

    logic [ADDR_W-1:0] s1_addr;
    logic [EXP_W-1:0]  s1_exp;
    logic [FLD_W-1:0]  s1_len;
    logic [FLD_W-1:0]  s1_low;

    logic [FLD_W:0]    sum;
    logic [63:0]       packed_ptr;

    logic [63:0]       s2_ptr;
    logic              s2_carry;

    // Upper pointer bits are intentionally ignored.
    logic unused_ptr_hi;
    assign unused_ptr_hi = ^in_ptr[63:ADDR_W];

    assign s2_adv     = !s2_vld || out_rdy;
    assign in_rdy     = !s1_vld || s2_adv;
    assign in_fire    = in_vld && in_rdy && !flush;
    assign s1_load_s2 = s2_adv && s1_vld && !flush;

    assign in_addr   = in_ptr[ADDR_W-1:0];
    assign in_exp    = in_bnd[EXP_W+FLD_W-1:FLD_W];
    assign in_len    = in_bnd[FLD_W-1:0];
    assign in_sh_amt = 32'(in_exp) + 32'(LSB_SH);

    // A logical right shift fills with zeros, so bits at or above ADDR_W read as 0.
    assign in_shifted = in_addr >> in_sh_amt;
    assign in_low     = in_shifted[FLD_W-1:0];

`ifdef AGUSEC_BND_FAULT_EN
    logic        in_oor;
    logic        s1_oor;
    logic        s2_fault;
    logic        fault;

    assign in_oor = (32'(in_exp) + 32'(LSB_SH) + 32'(FLD_W)) > 32'(ADDR_W);
`endif

    // Stage 1: capture operands and the exponent-scaled low field.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_addr <= '0;
            s1_exp  <= '0;
            s1_len  <= '0;
            s1_low  <= '0;
`ifdef AGUSEC_BND_FAULT_EN
            s1_oor  <= 1'b0;
`endif
        end else begin
            if (flush) begin
                s1_vld <= 1'b0;
            end else if (in_rdy) begin
                s1_vld <= in_vld;
            end
            if (in_fire) begin
                s1_addr <= in_addr;
                s1_exp  <= in_exp;
                s1_len  <= in_len;
                s1_low  <= in_low;
`ifdef AGUSEC_BND_FAULT_EN
                s1_oor  <= in_oor;
`endif
            end
        end
    end

    // Stage 2 datapath: bounded add and field packing.
    always_comb begin
        sum        = {1'b0, s1_low} + {1'b0, s1_len};
        packed_ptr = '0;
        packed_ptr[ADDR_W-1:0]        = s1_addr;
        packed_ptr[LOW_LSB +: FLD_W]  = s1_low;
        packed_ptr[HI_LSB +: FLD_W]   = sum[FLD_W-1:0];
        packed_ptr[EXP_LSB +: EXP_W]  = s1_exp;
`ifdef AGUSEC_BND_FAULT_EN
        fault                = sum[FLD_W] | s1_oor;
        packed_ptr[ONL_BIT]  = !fault;
`else
        packed_ptr[ONL_BIT]  = 1'b1;
`endif
    end

    // Stage 2 register: holds its contents while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_vld   <= 1'b0;
            s2_ptr   <= '0;
            s2_carry <= 1'b0;
`ifdef AGUSEC_BND_FAULT_EN
            s2_fault <= 1'b0;
`endif
        end else begin
            if (flush) begin
                s2_vld <= 1'b0;
            end else if (s2_adv) begin
                s2_vld <= s1_vld;
            end
            if (s1_load_s2) begin
                s2_ptr   <= packed_ptr;
                s2_carry <= sum[FLD_W];
`ifdef AGUSEC_BND_FAULT_EN
                s2_fault <= fault;
`endif
            end
        end
    end

    assign out_vld   = s2_vld;
    assign out_ptr   = s2_ptr;
    assign out_carry = s2_carry;
`ifdef AGUSEC_BND_FAULT_EN
    assign out_fault = s2_fault;
`endif

endmodule

// File: doc/agusec_bnd_enc_pipe.md
Name: agusec_bnd_enc_pipe

Overview:
- Pipelined, parametrised bounded-pointer encoder for the address-generation security path.
- Takes a raw pointer and a bounds descriptor {exponent, length}. Extracts the exponent-scaled low field from the pointer, computes hi = low + length, and packs {on_low, exp, hi, low, address} into one 64-bit encoded pointer.
- Sits between AGU operand fetch and the LSQ pointer-tag check.
- Two-stage valid/ready pipeline with flush, replacing the earlier single-cycle combinational encoder.

Parameters:
- ADDR_W, 44, address bits passed through unchanged in out_ptr[ADDR_W-1:0].
- EXP_W, 5, exponent field width.
- FLD_W, 7, width of the low and hi fields.
- LSB_SH, 5, fixed bit offset of the low field above the exponent shift.
- Legality: ADDR_W + 2*FLD_W + EXP_W + 1 must not exceed 64. Any remaining bits are zero-filled.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  kills all in-flight entries.
- in_vld  in  1  input entry valid.
- in_rdy  out  1  stage 1 can accept an entry.
- in_ptr  in  64  raw pointer; only [ADDR_W-1:0] is used.
- in_bnd  in  EXP_W+FLD_W  bits [EXP_W+FLD_W-1:FLD_W] = exp, bits [FLD_W-1:0] = len.
- out_vld  out  1  encoded entry valid.
- out_rdy  in  1  consumer accepts the entry.
- out_ptr  out  64  encoded pointer.
- out_carry  out  1  carry out of the hi-field add.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: all valid bits 0, so out_vld=0 and in_rdy=1. out_ptr=0 and out_carry=0.
- Stage 1 (S1), on capture:
  - Registers exp, len and addr.
  - low = addr[exp+LSB_SH+FLD_W-1 : exp+LSB_SH].
  - Address bits at or above ADDR_W read as 0. Out-of-range exponents therefore produce zero-extended low fields, not X.
- Stage 2 (S2):
  - {carry, hi} = low + len, as a (FLD_W+1)-bit unsigned add. hi wraps modulo 2^FLD_W.
  - Registers the packed result:
    - out_ptr[ADDR_W-1:0] = addr.
    - next FLD_W bits = low.
    - next FLD_W bits = hi.
    - next EXP_W bits = exp.
    - next bit = on_low = 1.
    - remaining upper bits = 0.
  - out_carry = carry.
- Latency: 2 cycles from an in_vld&&in_rdy handshake to out_vld, given no back-pressure.
- Throughput: 1 entry per cycle.
- Handshake:
  - S2 advances when !s2_vld || out_rdy.
  - S1 advances into S2 under the same condition.
  - in_rdy = !s1_vld || (!s2_vld || out_rdy). This is combinational, with no dependency on in_vld.
  - A stalled stage holds its data and valid bit unchanged.
  - out_ptr and out_carry stay stable while out_vld && !out_rdy.
- Flush:
  - Synchronous. On the cycle flush=1, s1_vld and s2_vld clear at the next edge.
  - Any input handshaking in the same cycle is dropped.
  - in_rdy is unaffected by flush within that cycle.
  - Data registers need not clear.
- Simultaneous events:
  - Full pipe with out_rdy=1 and in_vld=1: all three transfers occur in one edge, with no bubble.
  - flush and rst together: rst dominates.
- Reset mid-operation: every valid bit drops immediately (asynchronous). No partial output is emitted after rst deasserts.

Optional Feature:
- Macro: AGUSEC_BND_FAULT_EN.
- When defined:
  - Adds output out_fault (1 bit), registered in S2.
  - out_fault = carry, OR exp+LSB_SH+FLD_W > ADDR_W.
  - Faulting entries still propagate.
  - out_ptr bit on_low is forced to 0 for faulting entries, so the LSQ treats the pointer as untagged.
- When undefined: no out_fault port, and on_low is always 1.

Test Plan:
- Basic encode with defaults: in_ptr=0x12345678, exp=0, len=0x10 → 2 cycles later out_vld=1, out_ptr=0x821B300012345678 (low=0x33, hi=0x43), out_carry=0.
- Carry case: in_ptr=0xFE0, exp=0, len=0x01 → low=0x7F, hi=0x00, out_carry=1. With AGUSEC_BND_FAULT_EN: out_fault=1 and out_ptr[63]=0.
- Exponent shift: in_ptr=0x12345678, exp=3, len=0 → low=hi=0x56, out_ptr[62:58]=3.
- Back-pressure: stream 4 back-to-back entries with out_rdy=0 for 3 cycles.
  - in_rdy falls after 2 entries are captured.
  - Outputs stay stable while stalled.
  - All 4 entries emerge in order, with no loss or duplication.
- Flush: flush asserted while S1 and S2 are both valid, with in_vld=1 in the same cycle → next cycle out_vld=0. No stale entry appears later. An entry sent the cycle after flush appears 2 cycles later.
- Async reset mid-stream: assert rst between edges with the pipe full → out_vld=0 immediately, in_rdy=1, and no output after release until new input arrives.
